// File: rtl/coin_pkg.sv
// Shared types and constants for the coin credit accumulator: FSM state encoding
// and the credit value of each coin channel, in units of 100.
package coin_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSE = 2'd1,
        RETURN   = 2'd2
    } state_t;

    localparam int unsigned NUM_COIN_TYPES = 2;

    // Channel 0 is the 100 coin, channel 1 the 500 coin.
    localparam int unsigned COIN_VALUE [NUM_COIN_TYPES] = '{1, 5};

endpackage

// File: rtl/coin_edge_sync.sv
// One coin channel: 2-FF synchroniser followed by a rising-edge detector that
// produces a single-cycle event per press.
module coin_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic coin_raw,
    output logic coin_event
);

    logic       sync1;
    logic       sync2;
    logic       prev;
    logic [2:0] warm;

    // NOTE: async active-low reset; all state uses non-blocking assignments so
    // every flop samples the pre-edge value of its neighbour.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
            warm  <= 3'b000;
        end else begin
            sync1 <= coin_raw;
            sync2 <= sync1;
            prev  <= sync2;
            warm  <= {warm[1:0], 1'b1};
        end
    end

    // prev only holds a genuine sample three edges after reset release, so a
    // button already held down when reset lifts never looks like a fresh press.
    assign coin_event = sync2 & ~prev & warm[2];

endmodule

// File: rtl/coin_credit_accumulator.sv
// Coin credit accumulator: collects coin credit up to a ceiling, vends against a
// price, and hands back change through a valid/ack handshake.
module coin_credit_accumulator
    import coin_pkg::*;
#(
    parameter int NUM_COINS  = 2,
    parameter int CREDIT_W   = 8,
    parameter int MAX_CREDIT = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_COINS-1:0] coin_in,
    input  logic [CREDIT_W-1:0]  price,
    input  logic                 buy,
    input  logic                 cancel,
    input  logic                 change_ack,
    output logic [CREDIT_W-1:0]  credit,
    output logic                 dispense,
    output logic                 change_valid,
    output logic [CREDIT_W-1:0]  change_amount,
    output logic                 coin_rejected,
    output logic                 insufficient,
    output logic                 busy
);

    localparam logic [CREDIT_W:0] MAX_W = (CREDIT_W + 1)'(MAX_CREDIT);

    logic [NUM_COINS-1:0] coin_evt;
    logic [CREDIT_W-1:0]  coin_val [NUM_COINS];

    for (genvar i = 0; i < NUM_COINS; i++) begin : g_ch
        coin_edge_sync u_sync (
            .clk        (clk),
            .reset      (reset),
            .coin_raw   (coin_in[i]),
            .coin_event (coin_evt[i])
        );
        if (i < NUM_COIN_TYPES) begin : g_val
            assign coin_val[i] = CREDIT_W'(COIN_VALUE[i]);
        end else begin : g_none
            assign coin_val[i] = '0;
        end
    end

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] change_q, change_d;
    logic                rej_q, rej_d;
    logic                insuf_q, insuf_d;

    logic                sel_found;
    logic                extra_coin;
    logic [CREDIT_W-1:0] sel_val;
    logic [CREDIT_W:0]   sum;

    // Lowest-index event wins; any further simultaneous event is refused.
    always_comb begin
        sel_found  = 1'b0;
        extra_coin = 1'b0;
        sel_val    = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            if (coin_evt[i]) begin
                if (!sel_found) begin
                    sel_found = 1'b1;
                    sel_val   = coin_val[i];
                end else begin
                    extra_coin = 1'b1;
                end
            end
        end
        sum = {1'b0, credit_q} + {1'b0, sel_val};
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        change_d = change_q;
        rej_d    = 1'b0;
        insuf_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cancel) begin
                    rej_d = |coin_evt;
                    if (credit_q != '0) begin
                        change_d = credit_q;
                        credit_d = '0;
                        state_d  = RETURN;
                    end
                end else if (buy) begin
                    rej_d = |coin_evt;
                    if (price != '0 && credit_q >= price) begin
                        change_d = credit_q - price;
                        credit_d = '0;
                        state_d  = DISPENSE;
                    end else begin
                        insuf_d = 1'b1;
                    end
                end else if (sel_found) begin
                    if (sum > MAX_W) rej_d = 1'b1;
                    else             credit_d = sum[CREDIT_W-1:0];
                    if (extra_coin) rej_d = 1'b1;
                end
            end
            DISPENSE: begin
                rej_d   = |coin_evt;
                state_d = (change_q != '0) ? RETURN : IDLE;
            end
            RETURN: begin
                rej_d = |coin_evt;
                if (change_ack) begin
                    state_d  = IDLE;
                    change_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            credit_q <= '0;
            change_q <= '0;
            rej_q    <= 1'b0;
            insuf_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            change_q <= change_d;
            rej_q    <= rej_d;
            insuf_q  <= insuf_d;
        end
    end

    assign credit        = credit_q;
    assign change_amount = change_q;
    assign coin_rejected = rej_q;
    assign insufficient  = insuf_q;
    assign dispense      = (state_q == DISPENSE);
    assign change_valid  = (state_q == RETURN);
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_coin_credit_accumulator.sv
// Scoreboard bench for coin_credit_accumulator: stimulus pushes expected output
// events, a negedge monitor pops and compares whenever the outputs change.
module tb_coin_credit_accumulator;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] coin_in;
    logic [7:0] price;
    logic       buy, cancel, change_ack;
    logic [7:0] credit, change_amount;
    logic       dispense, change_valid, coin_rejected, insufficient, busy;

    coin_credit_accumulator #(.NUM_COINS(2), .CREDIT_W(8), .MAX_CREDIT(20)) dut (
        .clk           (clk),
        .reset         (reset),
        .coin_in       (coin_in),
        .price         (price),
        .buy           (buy),
        .cancel        (cancel),
        .change_ack    (change_ack),
        .credit        (credit),
        .dispense      (dispense),
        .change_valid  (change_valid),
        .change_amount (change_amount),
        .coin_rejected (coin_rejected),
        .insufficient  (insufficient),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  credit;
        logic        disp;
        logic        cv;
        logic [7:0]  ch;
        logic        rej;
        logic        ins;
    } ev_t;

    ev_t         exp_q[$];
    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] cyc        = 0;
    int          m_credit   = 0;
    int          coin_val [2] = '{1, 5};
    localparam int MAX_CREDIT = 20;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int c, input int cr, input logic d, input logic cv,
                        input int ch, input logic rej, input logic ins);
        exp_q.push_back('{32'(c), 8'(cr), d, cv, 8'(ch), rej, ins});
    endtask

    // Monitor: any visible output activity is one event to be matched in order.
    logic [7:0] last_credit = 0;
    logic       last_cv     = 0;
    always @(negedge clk) begin
        ev_t obs, e;
        if (reset !== 1'b1) begin
            last_credit = 0;
            last_cv     = 0;
        end else begin
            if (credit != last_credit || dispense || coin_rejected || insufficient ||
                change_valid != last_cv) begin
                obs = '{cyc, credit, dispense, change_valid, change_amount, coin_rejected, insufficient};
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_event: cyc=%0d credit=%0d disp=%0b cv=%0b ch=%0d rej=%0b ins=%0b, none expected",
                             obs.cyc, obs.credit, obs.disp, obs.cv, obs.ch, obs.rej, obs.ins);
                end else begin
                    e = exp_q.pop_front();
                    if (obs !== e) begin
                        mismatched++;
                        $display("FAIL event: got cyc=%0d credit=%0d disp=%0b cv=%0b ch=%0d rej=%0b ins=%0b, expected cyc=%0d credit=%0d disp=%0b cv=%0b ch=%0d rej=%0b ins=%0b",
                                 obs.cyc, obs.credit, obs.disp, obs.cv, obs.ch, obs.rej, obs.ins,
                                 e.cyc, e.credit, e.disp, e.cv, e.ch, e.rej, e.ins);
                    end
                end
            end
            last_credit = credit;
            last_cv     = change_valid;
        end
    end

    // One transaction: coin press at cycle c (event evaluated at c+3), with buy/cancel
    // presented so they are sampled on that same edge; then acknowledge any change.
    task automatic txn(input logic [1:0] mask, input logic b, input logic cn, input logic [7:0] p);
        int   c, e, ch, v, a;
        logic rej, ret, disp_path;
        @(posedge clk); #1;
        c = int'(cyc); e = c + 3;
        coin_in = mask;
        rej = (mask != 0) && (b || cn);
        ret = 0; disp_path = 0; ch = 0;
        if (cn) begin
            if (m_credit > 0) begin
                ch = m_credit; m_credit = 0; ret = 1;
                push(e, 0, 0, 1, ch, rej, 0);
            end else if (rej) begin
                push(e, m_credit, 0, 0, 0, 1, 0);
            end
        end else if (b) begin
            if (p != 0 && m_credit >= int'(p)) begin
                ch = m_credit - int'(p); m_credit = 0; disp_path = 1;
                push(e, 0, 1, 0, ch, rej, 0);
                if (ch > 0) begin
                    push(e + 1, 0, 0, 1, ch, 0, 0);
                    ret = 1;
                end
            end else begin
                push(e, m_credit, 0, 0, 0, rej, 1);
            end
        end else if (mask != 0) begin
            v = mask[0] ? coin_val[0] : coin_val[1];
            if (m_credit + v > MAX_CREDIT) rej = 1;
            else                           m_credit += v;
            if (mask == 2'b11) rej = 1;
            push(e, m_credit, 0, 0, 0, rej, 0);
        end
        repeat (2) @(posedge clk);
        #1; buy = b; cancel = cn; price = p;
        @(posedge clk); #1;
        buy = 0; cancel = 0;
        // A stray ack while dispensing must be ignored.
        if (disp_path) change_ack = 1'($urandom % 2);
        @(posedge clk); #1;
        change_ack = 0;
        if (ret) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            a = int'(cyc);
            push(a + 1, 0, 0, 0, 0, 0, 0);
            change_ack = 1;
            @(posedge clk); #1;
            change_ack = 0;
        end
        @(posedge clk); #1;
        coin_in = 0;
        repeat (3) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, expected finish");
        $fatal(1);
    end

    initial begin
        int r;
        logic [1:0] m;
        reset = 0; coin_in = 0; price = 0; buy = 0; cancel = 0; change_ack = 0;
        #23;
        check("rst_credit", credit, 0);
        check("rst_busy", busy, 0);
        check("rst_change_valid", change_valid, 0);
        reset = 1;
        repeat (5) @(posedge clk);

        // Basic accumulation and vend with change.
        repeat (3) txn(2'b01, 0, 0, 0);
        txn(2'b10, 0, 0, 0);
        check("credit_after_coins", credit, 8);
        txn(2'b00, 1, 0, 8'd6);
        check("credit_after_vend", credit, 0);
        // Exact price, then insufficient.
        txn(2'b10, 0, 0, 0); txn(2'b01, 0, 0, 0);
        txn(2'b00, 1, 0, 8'd6);
        repeat (4) txn(2'b01, 0, 0, 0);
        txn(2'b00, 1, 0, 8'd6);
        check("credit_after_insufficient", credit, 4);
        // Cancel beats buy; both coins at once.
        txn(2'b01, 0, 0, 0);
        txn(2'b00, 1, 1, 8'd1);
        txn(2'b11, 0, 0, 0);
        // Ceiling: 18, reject 500, then 100 up to exactly 20, reject the next.
        repeat (3) txn(2'b10, 0, 0, 0);
        repeat (2) txn(2'b01, 0, 0, 0);
        txn(2'b10, 0, 0, 0);
        check("credit_at_18", credit, 18);
        txn(2'b01, 0, 0, 0);
        txn(2'b01, 0, 0, 0);
        txn(2'b01, 0, 0, 0);
        check("credit_at_ceiling", credit, 20);
        // Zero price, coin with buy, cancel, cancel with nothing held.
        txn(2'b00, 1, 0, 8'd0);
        txn(2'b01, 1, 0, 8'd30);
        txn(2'b00, 0, 1, 0);
        txn(2'b10, 0, 1, 0);

        for (int i = 0; i < 80; i++) begin
            r = $urandom % 8;
            m = 2'($urandom_range(1, 3));
            if (r < 5)       txn(m, 0, 0, 0);
            else if (r == 5) txn(2'b00, 1, 0, 8'($urandom_range(0, 12)));
            else if (r == 6) txn(2'b00, 0, 1, 0);
            else             txn(m, 1, 0, 8'($urandom_range(0, 12)));
        end

        // Reset in RETURN with change 3, coin held high across release.
        if (m_credit > 0) txn(2'b00, 0, 1, 0);
        repeat (3) txn(2'b01, 0, 0, 0);
        @(posedge clk); #1;
        push(int'(cyc) + 1, 0, 0, 1, 3, 0, 0);
        cancel = 1;
        @(posedge clk); #1;
        cancel = 0;
        @(negedge clk); #2;
        coin_in = 2'b11;
        reset = 0;
        #1;
        check("arst_credit", credit, 0);
        check("arst_change_amount", change_amount, 0);
        check("arst_change_valid", change_valid, 0);
        check("arst_dispense", dispense, 0);
        check("arst_busy", busy, 0);
        check("arst_rej_ins", {30'd0, coin_rejected, insufficient}, 0);
        m_credit = 0;
        repeat (2) @(posedge clk);
        #3; reset = 1;
        repeat (6) @(posedge clk);
        #1;
        check("held_coin_ignored", credit, 0);
        coin_in = 0;
        repeat (3) @(posedge clk);
        txn(2'b01, 0, 0, 0);
        check("credit_after_recovery", credit, 1);

        repeat (5) @(posedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/coin_credit_accumulator.md
COIN_CREDIT_ACCUMULATOR -- requirements
Module: coin_credit_accumulator

Interface
REQ-001 The block SHALL have parameter NUM_COINS, default 2, giving the number of coin input channels.
REQ-002 The block SHALL have parameter CREDIT_W, default 8, giving the credit and price width in units of 100.
REQ-003 The block SHALL have parameter MAX_CREDIT, default 20, giving the credit ceiling in units of 100.
REQ-004 The block SHALL have port clk, input, 1, system clock, rising edge.
REQ-005 The block SHALL have port reset, input, 1; reset is asynchronous, active-low.
REQ-006 The block SHALL have port coin_in, input, NUM_COINS, raw asynchronous coin buttons; bit i carries value COIN_VALUE[i].
REQ-007 The block SHALL have port price, input, CREDIT_W, item price, sampled on buy.
REQ-008 The block SHALL have port buy, input, 1, purchase request, level sampled per cycle.
REQ-009 The block SHALL have port cancel, input, 1, return-all request.
REQ-010 The block SHALL have port change_ack, input, 1, change taken.
REQ-011 The block SHALL have port credit, output, CREDIT_W, current accumulated credit.
REQ-012 The block SHALL have port dispense, output, 1, one-cycle vend pulse.
REQ-013 The block SHALL have port change_valid, output, 1, change_amount valid.
REQ-014 The block SHALL have port change_amount, output, CREDIT_W, change to return.
REQ-015 The block SHALL have port coin_rejected, output, 1, one-cycle pulse per refused coin.
REQ-016 The block SHALL have port insufficient, output, 1, one-cycle pulse on buy with too little credit.
REQ-017 The block SHALL have port busy, output, 1, high whenever state != IDLE.

Function
REQ-018 Each coin_in bit SHALL pass a 2-FF synchroniser plus rising-edge detector, giving a single event per press.
REQ-019 In IDLE, a coin event SHALL update credit on the 3rd rising clk edge after coin_in goes high.
REQ-020 When several coin events occur in one cycle, the lowest-index coin SHALL be evaluated and every other coin SHALL be rejected.
REQ-021 A coin SHALL be rejected, with credit unchanged, if credit + COIN_VALUE > MAX_CREDIT; the addition SHALL be computed at CREDIT_W+1 bits, with no wrap.
REQ-022 A coin event SHALL be rejected when the state is not IDLE, or when buy or cancel is asserted in the same cycle.
REQ-023 The FSM SHALL have states IDLE, DISPENSE and RETURN.
REQ-024 In IDLE, if cancel=1 and credit>0, the FSM SHALL go to RETURN with change_amount=credit and credit=0; if credit=0, cancel SHALL be ignored.
REQ-025 In IDLE, buy=1 with cancel=0, price!=0 and credit>=price SHALL latch change_amount=credit-price, clear credit and go to DISPENSE.
REQ-026 In IDLE, buy=1 with credit<price or price=0 SHALL pulse insufficient for one cycle and SHALL leave state and credit unchanged.
REQ-027 If cancel and buy are asserted together, cancel SHALL have priority.
REQ-028 In DISPENSE, dispense=1 SHALL be asserted for exactly one cycle, then the FSM SHALL go to RETURN if change_amount>0, else to IDLE.
REQ-029 In RETURN, change_valid=1 SHALL hold, with change_amount stable, until the first cycle with change_ack=1; the FSM SHALL then go to IDLE, with change_valid=0 and change_amount=0 the following cycle.
REQ-030 change_ack outside RETURN, and buy or cancel outside IDLE, SHALL be ignored.

Reset
REQ-031 When reset=0, all outputs SHALL immediately be 0 (credit, change_amount, dispense, change_valid, coin_rejected, insufficient, busy), the state SHALL be IDLE, and the synchroniser and edge flops SHALL be cleared.
REQ-032 Reset mid-transaction SHALL discard pending credit and change, with no dispense pulse.
REQ-033 A coin_in level held high across reset release SHALL NOT register as a coin.

Structure
REQ-034 Package coin_pkg SHALL hold the FSM state enum and the COIN_VALUE constant array, default {1,5} (100 and 500).
REQ-035 The sub-module coin_edge_sync SHALL implement the per-channel synchroniser and edge detector, instantiated NUM_COINS times.

Verification
REQ-036 Reset, then coin 100 ×3 and coin 500 ×1 -> credit=8; 3-cycle latency on each event; coin_rejected never asserted.
REQ-037 Credit=18, press coin 500 -> coin_rejected pulse, credit=18; then press coin 100 -> credit=19.
REQ-038 Credit=8, price=6, buy -> one dispense pulse, then change_valid=1 with change_amount=2 held until change_ack, then IDLE with credit=0.
REQ-039 Credit=6, price=6, buy -> dispense pulse, no change_valid, returns to IDLE; credit=4, price=6, buy -> insufficient pulse, credit=4.
REQ-040 Credit=5, buy and cancel asserted together -> RETURN with change_amount=5 and no dispense; both coins pressed in the same cycle -> +1 and coin_rejected.
REQ-041 Reset asserted while in RETURN with change_amount=3 -> all outputs 0 asynchronously; coin_in high at reset release -> credit stays 0.
